// File: rtl/rv_pkg.sv
// Shared types for the register-file write-back path.
// Contents:
//   XLEN, REG_IDX_W  - data width and register index width
//   wb_entry_t       - one pending register write {rd, data}
//   fwd_t            - result of a pending/forward lookup {pend, data}
//   wb_src_t         - which producer won arbitration this cycle
//   is_x0()          - true for the hard-wired zero register
package rv_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  typedef struct packed {
    logic            pend;
    logic [XLEN-1:0] data;
  } fwd_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_ALU
  } wb_src_t;

  function automatic logic is_x0(input logic [REG_IDX_W-1:0] rd);
    return rd == '0;
  endfunction

endpackage

// File: rtl/reg_writeback_unit_if.sv
// Producer-side bus of the write-back unit: the load-result channel and the
// ALU-result channel, each a valid/ready handshake carrying {rd, data}.
// Modports:
//   master - the execute/memory stages (drive valid/rd/data, see ready)
//   slave  - the write-back unit (sees valid/rd/data, drives ready)
interface reg_writeback_unit_if;
  import rv_pkg::*;

  logic                 mem_valid;
  logic [REG_IDX_W-1:0] mem_rd;
  logic [XLEN-1:0]      mem_data;
  logic                 mem_ready;

  logic                 alu_valid;
  logic [REG_IDX_W-1:0] alu_rd;
  logic [XLEN-1:0]      alu_data;
  logic                 alu_ready;

  modport master (
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready
  );

  modport slave (
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular FIFO of pending register writes.
// Ports:
//   clk, reset   - clock, synchronous active-high reset (drops all entries)
//   push, push_entry - enqueue at the tail (ignored when full)
//   pop          - dequeue the head (ignored when empty)
//   head         - entry at the head, meaningful when !empty
//   full, empty  - occupancy flags from the registered count
//   entries      - raw storage, for the pending-write scan
//   entry_valid  - one bit per slot, set while the slot holds a live entry
//   head_ptr     - slot index of the oldest entry
module wb_fifo
  import rv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output logic                  full,
  output logic                  empty,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      entry_valid,
  output logic [PTR_W-1:0]      head_ptr
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head     = mem[rd_ptr];
  assign head_ptr = rd_ptr;
  assign entries  = mem;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // Push and pop never target the same slot: push needs !full, pop needs !empty.
      if (do_pop)  entry_valid[rd_ptr] <= 1'b0;
      if (do_push) entry_valid[wr_ptr] <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; entry_valid and count alone decide
  // which slots are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side driver for the 32x32 register file. Arbitrates the load and ALU
// result channels (load first), buffers accepted writes in a FIFO, retires one
// write per cycle into a registered RegWrite/writeReg/writeData stage, and
// answers two hazard queries with pending status plus youngest pending data.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   src                  - producer bus (slave side): mem_* and alu_* channels
//   RegWrite, writeReg, writeData - registered register-file write port
//   q_rs1, q_rs2         - hazard query register indices
//   pend1, pend2         - query register has a write not yet retired
//   fwd1, fwd2           - data of the youngest such write, 0 if none
//   empty                - nothing queued and no write in the output stage
module reg_writeback_unit
  import rv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_writeback_unit_if.slave  src,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] writeReg,
  output logic [XLEN-1:0]      writeData,
  input  logic [REG_IDX_W-1:0] q_rs1,
  input  logic [REG_IDX_W-1:0] q_rs2,
  output logic                 pend1,
  output logic                 pend2,
  output logic [XLEN-1:0]      fwd1,
  output logic [XLEN-1:0]      fwd2,
  output logic                 empty
);

  wb_src_t               sel;
  wb_entry_t             push_entry;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      entry_valid;
  logic [PTR_W-1:0]      head_ptr;
  wb_entry_t             out_entry;
  fwd_t                  scan1;
  fwd_t                  scan2;

  // Ready depends only on the registered count and mem_valid, never on
  // alu_valid, so producers cannot form a combinational loop through it.
  assign src.mem_ready = !fifo_full;
  assign src.alu_ready = !fifo_full && !src.mem_valid;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    sel        = SRC_NONE;
    push_entry = '0;
    if (src.mem_valid && src.mem_ready) begin
      sel        = SRC_MEM;
      push_entry = '{rd: src.mem_rd, data: src.mem_data};
    end else if (src.alu_valid && src.alu_ready) begin
      sel        = SRC_ALU;
      push_entry = '{rd: src.alu_rd, data: src.alu_data};
    end
  end

  // A write to x0 completes its handshake but is dropped here.
  assign push = (sel != SRC_NONE) && !is_x0(push_entry.rd);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (!fifo_empty),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entries     (entries),
    .entry_valid (entry_valid),
    .head_ptr    (head_ptr)
  );

  // Output stage: every edge with a queued entry retires it; otherwise the
  // enable drops and index/data hold their last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite  <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (!fifo_empty) begin
      RegWrite  <= 1'b1;
      writeReg  <= head.rd;
      writeData <= head.data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

  assign out_entry = '{rd: writeReg, data: writeData};
  assign empty     = fifo_empty && !RegWrite;

  // The output stage is older than anything in the FIFO, so it is checked
  // first; FIFO slots are then walked from head (oldest) towards tail
  // (youngest) so that the last match, the youngest write, overrides.
  function automatic fwd_t scan_pending(
    input logic [REG_IDX_W-1:0] q,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]      vld,
    input logic [PTR_W-1:0]      first,
    input logic                  out_valid,
    input wb_entry_t             out_e
  );
    fwd_t             r;
    logic [PTR_W-1:0] idx;
    r = '0;
    if (!is_x0(q)) begin
      if (out_valid && out_e.rd == q) r = '{pend: 1'b1, data: out_e.data};
      for (int i = 0; i < DEPTH; i++) begin
        idx = first + PTR_W'(i);
        if (vld[idx] && ents[idx].rd == q) r = '{pend: 1'b1, data: ents[idx].data};
      end
    end
    return r;
  endfunction

  assign scan1 = scan_pending(q_rs1, entries, entry_valid, head_ptr, RegWrite, out_entry);
  assign scan2 = scan_pending(q_rs2, entries, entry_valid, head_ptr, RegWrite, out_entry);

  assign pend1 = scan1.pend;
  assign fwd1  = scan1.data;
  assign pend2 = scan2.pend;
  assign fwd2  = scan2.data;

endmodule
